// File: rtl/udp_audio_tx_ctrl.sv
// Streams 16-bit audio samples from a FIFO into a UDP core as big-endian bytes,
// sending full packets when enough samples are queued and flushing partial ones on a timeout.
module udp_audio_tx_ctrl #(
    parameter int PKT_SAMPLES  = 256,
    parameter int FLUSH_CYCLES = 50000,
    parameter int GAP_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_en,
    input  logic [11:0] wav_rd_count,
    output logic        wav_rden,
    input  logic [15:0] wav_out_data,
    output logic        udp_send_data_valid,
    input  logic        udp_send_data_ready,
    output logic [7:0]  udp_send_data,
    output logic [15:0] udp_send_data_length,
    output logic        tx_busy,
    output logic [15:0] pkt_cnt
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [11:0]   PKT_N      = 12'(PKT_SAMPLES);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WT,
        HI,
        LO,
        GAP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [FW-1:0] flush_timer;
    logic [GW-1:0] gap_cnt;
    logic [11:0]   remaining;
    logic [15:0]   sample;

    logic          full_ready;
    logic          flush_window;
    logic          flush_due;
    logic          start_pkt;
    logic [11:0]   start_n;
    logic          sample_done;

    // A count of zero never opens the flush window, so it can never start a packet.
    assign full_ready   = tx_en && (wav_rd_count >= PKT_N);
    assign flush_window = tx_en && (wav_rd_count != 12'd0) && (wav_rd_count < PKT_N);
    assign flush_due    = flush_window && (flush_timer == FLUSH_LAST);

    assign tx_busy = (state != IDLE);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next          = state;
        start_pkt           = 1'b0;
        start_n             = PKT_N;
        sample_done         = 1'b0;
        wav_rden            = 1'b0;
        udp_send_data_valid = 1'b0;
        udp_send_data       = 8'h00;

        case (state)
            IDLE: begin
                if (full_ready) begin
                    start_pkt  = 1'b1;
                    start_n    = PKT_N;
                    state_next = RD;
                end else if (flush_due) begin
                    start_pkt  = 1'b1;
                    start_n    = wav_rd_count;
                    state_next = RD;
                end
            end
            RD: begin
                wav_rden   = 1'b1;
                state_next = WT;
            end
            WT: begin
                state_next = HI;
            end
            HI: begin
                udp_send_data_valid = 1'b1;
                udp_send_data       = sample[15:8];
                if (udp_send_data_ready) begin
                    state_next = LO;
                end
            end
            LO: begin
                udp_send_data_valid = 1'b1;
                udp_send_data       = sample[7:0];
                if (udp_send_data_ready) begin
                    sample_done = 1'b1;
                    state_next  = (remaining == 12'd1) ? GAP : RD;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_timer          <= '0;
            gap_cnt              <= '0;
            remaining            <= 12'd0;
            sample               <= 16'h0000;
            udp_send_data_length <= 16'h0000;
            pkt_cnt              <= 16'h0000;
        end else begin
            if ((state == IDLE) && !start_pkt && flush_window) begin
                flush_timer <= flush_timer + FW'(1);
            end else begin
                flush_timer <= '0;
            end

            if ((state == GAP) && (state_next == GAP)) begin
                gap_cnt <= gap_cnt + GW'(1);
            end else begin
                gap_cnt <= '0;
            end

            // Length is captured once per packet and held through the gap.
            if (start_pkt) begin
                remaining            <= start_n;
                udp_send_data_length <= {3'b000, start_n, 1'b0};
            end else if (sample_done) begin
                remaining <= remaining - 12'd1;
            end

            if (state == WT) begin
                sample <= wav_out_data;
            end

            if (sample_done && (remaining == 12'd1)) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/udp_audio_tx_ctrl.md
UDP_AUDIO_TX_CTRL -- requirements
Module: udp_audio_tx_ctrl

Interface
REQ-001 SHALL have parameter PKT_SAMPLES, default 256: 16-bit samples per full UDP packet (legal range 1..2047).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 50000: number of idle cycles with a non-empty FIFO after which a partial packet is forced.
REQ-003 SHALL have parameter GAP_CYCLES, default 16: minimum number of idle cycles between packets.
REQ-004 SHALL have the port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have the port tx_en, input, 1 bit: enables packet scheduling.
REQ-007 SHALL have the port wav_rd_count, input, 12 bits: sample count of the audio FIFO.
REQ-008 SHALL have the port wav_rden, output, 1 bit: one-cycle FIFO read strobe.
REQ-009 SHALL have the port wav_out_data, input, 16 bits: FIFO read data, valid 1 cycle after wav_rden.
REQ-010 SHALL have the port udp_send_data_valid, output, 1 bit: the byte on udp_send_data is valid.
REQ-011 SHALL have the port udp_send_data_ready, input, 1 bit: the UDP core accepts the byte.
REQ-012 SHALL have the port udp_send_data, output, 8 bits: payload byte.
REQ-013 SHALL have the port udp_send_data_length, output, 16 bits: payload length in bytes for the current packet.
REQ-014 SHALL have the port tx_busy, output, 1 bit: high while in any state other than IDLE.
REQ-015 SHALL have the port pkt_cnt, output, 16 bits: number of completed packets, wrapping modulo 2^16.

Function
REQ-016 SHALL implement the states IDLE, RD, WT, HI, LO and GAP.
REQ-017 In IDLE with tx_en=1 and wav_rd_count>=PKT_SAMPLES, SHALL latch n=PKT_SAMPLES and go to RD.
REQ-018 The flush timer SHALL count up in IDLE while tx_en=1 and 0<wav_rd_count<PKT_SAMPLES, and SHALL clear otherwise.
REQ-019 When the flush timer reaches FLUSH_CYCLES-1, SHALL latch n=wav_rd_count, go to RD and clear the timer.
REQ-020 If the full-packet and flush conditions are true in the same cycle, the full-packet condition SHALL win.
REQ-021 SHALL set udp_send_data_length to 2*n on the clock edge that leaves IDLE, and SHALL hold it constant until the next packet starts.
REQ-022 In RD, SHALL assert wav_rden for exactly one cycle, then go to WT.
REQ-023 In WT, SHALL register wav_out_data into a 16-bit sample register, then go to HI.
REQ-024 In HI, SHALL drive udp_send_data=sample[15:8] with valid=1, and go to LO on valid&ready.
REQ-025 In LO, SHALL drive udp_send_data=sample[7:0] with valid=1.
REQ-026 On valid&ready in LO, SHALL decrement the remaining sample count, go to RD if it is nonzero, and otherwise increment pkt_cnt and go to GAP.
REQ-027 While valid=1 and ready=0, SHALL hold udp_send_data and valid stable for any number of cycles.
REQ-028 SHALL never assert valid in the RD, WT, GAP or IDLE states; this gives a 2-cycle bubble per sample, which is allowed.
REQ-029 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE.
REQ-030 Deasserting tx_en mid-packet SHALL NOT abort the packet; the packet completes, then the block goes to IDLE and stays there.
REQ-031 SHALL assert wav_rden exactly n times per packet and SHALL never assert it outside RD (no FIFO underflow, because n<=count was latched).
REQ-032 A wav_rd_count value of 0 SHALL never start a packet.
REQ-033 pkt_cnt SHALL wrap from 16'hFFFF to 16'h0000.

Reset
REQ-034 While rst_n=0, asynchronously, SHALL set state=IDLE, wav_rden=0, udp_send_data_valid=0, udp_send_data=0, udp_send_data_length=0, tx_busy=0, pkt_cnt=0, flush timer=0 and sample register=0.
REQ-035 Reset asserted mid-packet SHALL abandon the packet; after release, the block SHALL restart from IDLE with no residual valid or rden.

Verification
REQ-036 Full packet test: PKT_SAMPLES=4, count=4, samples 1234/5678/9ABC/DEF0, ready=1 -> bytes 12 34 56 78 9A BC DE F0, length=8, 4 rden pulses, pkt_cnt=1, then GAP_CYCLES idle cycles.
REQ-037 Backpressure test: ready=0 for 5 cycles during the LO byte of sample 2 -> byte 78 held stable with valid=1 for those cycles, and the output stream is unchanged.
REQ-038 Flush test: FLUSH_CYCLES=100, count held at 3 -> packet starts exactly 100 cycles after the count became 3, length=6, 3 rden pulses.
REQ-039 Priority test: in the same cycle, count reaches PKT_SAMPLES and the flush timer expires -> length=2*PKT_SAMPLES.
REQ-040 tx_en test: tx_en dropped during byte 3 -> packet completes with 8 bytes, then tx_busy=0 and no new packet starts even with count>=4.
REQ-041 Reset test: rst_n pulsed low during the HI state -> all outputs 0 immediately, pkt_cnt=0, and a clean first packet follows after release.
